abc_sweep_checker: RTL
======================

// Module: abc_sweep_checker
// PURPOSE
//   Synthesizable on-board self-test stage that sits directly upstream of the
//   3-input combinational function block and consumes its output.
//   - Drives A/B/C through all 8 combinations, 000 to 111, in order.
//   - Holds each vector for a settle window, samples the returned Y, and builds
//     an 8-bit truth table.
//   - Compares the table with an expected constant and reports Done/Pass.
// PARAMETERS
//   HOLD_CYCLES  4      clocks each vector is held; Y is sampled on the last one (>=1)
//   EXPECTED     8'hE8  expected truth table; bit i = Y for {A,B,C}=i
// PORTS
//   Clk         in   1  rising-edge clock
//   Rst_n       in   1  asynchronous active-low reset
//   Start       in   1  level; sampled only in IDLE or DONE
//   Y           in   1  output of the function block under test
//   A           out  1  vector bit 2 (MSB)
//   B           out  1  vector bit 1
//   C           out  1  vector bit 0 (LSB)
//   Busy        out  1  high while a sweep is in progress
//   Done        out  1  high from sweep completion until the next Start or reset
//   Pass        out  1  valid when Done=1; 1 = table equals EXPECTED
//   TruthTable  out  8  captured Y values; bit i = vector i
// BEHAVIOUR
//   - Reset (async, Rst_n=0):
//     - state=IDLE; idx=0; cnt=0.
//     - A=B=C=0; Busy=Done=Pass=0; TruthTable=8'h00.
//     - Applies immediately, including mid-sweep. No partial result survives.
//   - All outputs are registered. {A,B,C} = idx[2:0] while in RUN, otherwise 3'b000.
//   - IDLE:
//     - Start=1 on an edge -> RUN; idx=0; cnt=0; TruthTable=0; Busy=1.
//   - RUN: each edge, cnt increments.
//     - When cnt==HOLD_CYCLES-1: TruthTable[idx]<=Y.
//       - If idx==7 -> DONE: Done=1; Busy=0;
//         Pass=({Y,TruthTable[6:0]}==EXPECTED). Pass uses the same-edge value of Y.
//       - Else: idx<=idx+1; cnt<=0.
//     - Start is ignored throughout RUN.
//   - DONE:
//     - Done, Pass and TruthTable hold.
//     - Start=1 -> same transition as from IDLE: Done=Pass=0, table cleared.
//   - Latency: with the Start-sampling edge as edge 0, vector i is driven for
//     edges i*H+1 .. (i+1)*H, where H=HOLD_CYCLES.
//     - Y for vector i is captured at edge (i+1)*H.
//     - Done rises at edge 8*H, i.e. 32 with defaults.
//   - The settle window covers the combinational path A/B/C -> Y within one
//     clock. No synchroniser is placed on Y.
//   - Widths:
//     - idx is 3 bits and never wraps inside a sweep; the idx==7 check ends it.
//     - cnt width is clog2(HOLD_CYCLES)+1.
//   - A constant Start=1 causes back-to-back sweeps, each separated by one DONE cycle.
// STRUCTURE
//   - Shared include abc_sweep_defs.vh holds:
//     - state localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//     - default EXPECTED and HOLD_CYCLES.
//   - Single module, no sub-modules: FSM, idx counter and hold counter are inline.
//   - Top level instantiates this block with the function block, Y looped back.
// TESTING
//   1. Hold Rst_n=0 -> A,B,C,Busy,Done,Pass=0 and TruthTable=8'h00.
//      Release Rst_n with Start=0 -> all outputs remain 0.
//   2. Loop back a majority-function Y model; pulse Start for 1 cycle ->
//      - {A,B,C} steps 000..111, each vector held 4 clocks;
//      - Done=1 at edge 32; TruthTable=8'hE8; Pass=1; Busy=0.
//   3. Tie Y=0 and run a sweep -> Done at edge 32, TruthTable=8'h00, Pass=0.
//      Then tie Y=1 and pulse Start -> TruthTable=8'hFF, Pass=0.
//   4. Hold Start=1 continuously -> no restart during RUN.
//      Done lasts exactly 1 cycle, then the next sweep begins with TruthTable cleared.
//   5. Drive Rst_n low for 1 cycle at edge 10 of a sweep -> outputs go to 0
//      asynchronously, before the next edge, and the FSM returns to IDLE.
//      A new Start completes normally.
//   6. With HOLD_CYCLES=1 -> vector changes every clock; Done at edge 8;
//      result identical to scenario 2.

Source files
------------

// File: rtl/abc_sweep_checker_pkg.sv
// Shared definitions for the A/B/C truth-table sweep checker: FSM state
// encoding and the default sweep parameters.
package abc_sweep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int         DEFAULT_HOLD_CYCLES = 4;
    localparam logic [7:0] DEFAULT_EXPECTED    = 8'hE8;
    localparam logic [2:0] LAST_IDX            = 3'd7;

endpackage

// File: rtl/abc_sweep_checker.sv
// On-board self-test: walks {A,B,C} through 000..111, samples the looped-back Y
// at the end of each hold window, and compares the captured table to EXPECTED.
module abc_sweep_checker
    import abc_sweep_checker_pkg::*;
#(
    parameter int         HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter logic [7:0] EXPECTED    = DEFAULT_EXPECTED
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [7:0] TruthTable,
    output logic [1:0] dbg_state
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    // Start is a level request taken on any edge while IDLE or DONE and ignored
    // while Busy; Done/Pass/TruthTable are sticky until the next accepted Start.
    sweep_state_t     state, state_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       table_n;
    logic             busy_n, done_n, pass_n;
    logic [2:0]       abc_n;

    assign dbg_state = state;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            TruthTable <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Pass       <= 1'b0;
            {A, B, C}  <= 3'b000;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            TruthTable <= table_n;
            Busy       <= busy_n;
            Done       <= done_n;
            Pass       <= pass_n;
            {A, B, C}  <= abc_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        table_n = TruthTable;
        busy_n  = Busy;
        done_n  = Done;
        pass_n  = Pass;

        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_n = RUN;
                    idx_n   = '0;
                    cnt_n   = '0;
                    table_n = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    table_n[idx] = Y;
                    cnt_n        = '0;
                    if (idx == LAST_IDX) begin
                        // Final bit is taken from Y directly; the register lags by one edge.
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        pass_n  = ({Y, TruthTable[6:0]} == EXPECTED);
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
                pass_n  = 1'b0;
            end
        endcase

        abc_n = (state_n == RUN) ? idx_n : 3'b000;
    end

endmodule
